// File: rtl/mtc_pair_aligner.sv
// Pairs each SLC pipeline word with the pT-calc result that has the same muon ID,
// then presents the pair to the MTC packet formatter with a valid/ready handshake.

module mtc_pair_aligner_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         ovf_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          full, do_pop, do_push;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_q];
  assign ovf_o   = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

module mtc_pair_aligner #(
  parameter int PL_WIDTH    = 64,
  parameter int PT_WIDTH    = 48,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 64,
  parameter int PL_MUID_LSB = 0,
  parameter int PT_MUID_LSB = 0,
  parameter int MUID_WIDTH  = 20,
  parameter int BUSY_BIT    = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PL_WIDTH-1:0] i_pl_data,
  input  logic                i_pl_valid,
  input  logic [PT_WIDTH-1:0] i_pt_data,
  input  logic                i_pt_valid,
  output logic [PL_WIDTH-1:0] o_slcpipeline,
  output logic [PT_WIDTH-1:0] o_ptcalc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_pl_overflow,
  output logic                o_pt_overflow,
  output logic [15:0]         o_timeout_cnt,
  output logic [15:0]         o_orphan_cnt
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, MATCH, EMIT} state_t;

  state_t              state_q;
  logic [TW-1:0]       timer_q;
  logic [PL_WIDTH-1:0] slc_q;
  logic [PT_WIDTH-1:0] pt_q;
  logic                valid_q;
  logic [15:0]         tmo_cnt_q, orph_cnt_q;

  logic [PL_WIDTH-1:0] pl_head;
  logic [PT_WIDTH-1:0] pt_head;
  logic                pl_empty, pt_empty;
  logic                pl_pop, pt_pop, load, load_pt, orphan, tmo;

  mtc_pair_aligner_fifo #(.W(PL_WIDTH), .DEPTH(DEPTH)) u_pl_fifo (
    .clk(clk), .rst(rst), .push_i(i_pl_valid), .data_i(i_pl_data), .pop_i(pl_pop),
    .data_o(pl_head), .empty_o(pl_empty), .ovf_o(o_pl_overflow)
  );

  mtc_pair_aligner_fifo #(.W(PT_WIDTH), .DEPTH(DEPTH)) u_pt_fifo (
    .clk(clk), .rst(rst), .push_i(i_pt_valid), .data_i(i_pt_data), .pop_i(pt_pop),
    .data_o(pt_head), .empty_o(pt_empty), .ovf_o(o_pt_overflow)
  );

  // Match decision on the current heads; busy beats match beats orphan beats timeout.
  always_comb begin
    pl_pop  = 1'b0;
    pt_pop  = 1'b0;
    load    = 1'b0;
    load_pt = 1'b0;
    orphan  = 1'b0;
    tmo     = 1'b0;
    if (state_q == MATCH && !pl_empty) begin
      if (pl_head[BUSY_BIT]) begin
        load   = 1'b1;
        pl_pop = 1'b1;
      end else if (!pt_empty && (pl_head[PL_MUID_LSB +: MUID_WIDTH] ==
                                 pt_head[PT_MUID_LSB +: MUID_WIDTH])) begin
        load    = 1'b1;
        load_pt = 1'b1;
        pl_pop  = 1'b1;
        pt_pop  = 1'b1;
      end else if (!pt_empty) begin
        pt_pop = 1'b1;
        orphan = 1'b1;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        load   = 1'b1;
        pl_pop = 1'b1;
        tmo    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      slc_q      <= '0;
      pt_q       <= '0;
      valid_q    <= 1'b0;
      tmo_cnt_q  <= '0;
      orph_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_pl_valid) state_q <= MATCH;
        end
        MATCH: begin
          if (load) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            slc_q   <= pl_head;
            pt_q    <= load_pt ? pt_head : '0;
            timer_q <= '0;
            if (tmo && tmo_cnt_q != 16'hFFFF) tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end else if (orphan) begin
            if (orph_cnt_q != 16'hFFFF) orph_cnt_q <= orph_cnt_q + 16'd1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        EMIT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= (!pl_empty || i_pl_valid) ? MATCH : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_slcpipeline = slc_q;
  assign o_ptcalc      = pt_q;
  assign o_valid       = valid_q;
  assign o_timeout_cnt = tmo_cnt_q;
  assign o_orphan_cnt  = orph_cnt_q;
endmodule

// File: tb/tb_mtc_pair_aligner.sv
// Directed bench for mtc_pair_aligner with a pair scoreboard on the output handshake.
module tb_mtc_pair_aligner;
  localparam int PLW = 32;
  localparam int PTW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [PLW-1:0] i_pl_data;
  logic           i_pl_valid;
  logic [PTW-1:0] i_pt_data;
  logic           i_pt_valid;
  logic [PLW-1:0] o_slcpipeline;
  logic [PTW-1:0] o_ptcalc;
  logic           o_valid;
  logic           i_ready;
  logic           o_pl_overflow;
  logic           o_pt_overflow;
  logic [15:0]    o_timeout_cnt;
  logic [15:0]    o_orphan_cnt;

  mtc_pair_aligner #(
    .PL_WIDTH(PLW), .PT_WIDTH(PTW), .DEPTH(8), .TIMEOUT(64),
    .PL_MUID_LSB(0), .PT_MUID_LSB(0), .MUID_WIDTH(20), .BUSY_BIT(24)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pl_data(i_pl_data), .i_pl_valid(i_pl_valid),
    .i_pt_data(i_pt_data), .i_pt_valid(i_pt_valid),
    .o_slcpipeline(o_slcpipeline), .o_ptcalc(o_ptcalc), .o_valid(o_valid),
    .i_ready(i_ready),
    .o_pl_overflow(o_pl_overflow), .o_pt_overflow(o_pt_overflow),
    .o_timeout_cnt(o_timeout_cnt), .o_orphan_cnt(o_orphan_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_pl_q[$];
  logic [31:0] exp_pt_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_emit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pl_w(input logic [6:0] tag, input logic busy, input logic [19:0] muid);
    return {tag, busy, 4'hA, muid};
  endfunction

  function automatic logic [31:0] pt_w(input logic [11:0] tag, input logic [19:0] muid);
    return {tag, muid};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pl(input logic [31:0] w);
    i_pl_data  = w;
    i_pl_valid = 1'b1;
    tick(1);
    i_pl_valid = 1'b0;
  endtask

  task automatic push_pt(input logic [31:0] w);
    i_pt_data  = w;
    i_pt_valid = 1'b1;
    tick(1);
    i_pt_valid = 1'b0;
  endtask

  task automatic expect_pair(input logic [31:0] pl, input logic [31:0] pt);
    exp_pl_q.push_back(pl);
    exp_pt_q.push_back(pt);
  endtask

  // Every accepted pair is checked against the next expected pair.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      n_emit++;
      if (exp_pl_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_pair: observed %0h/%0h expected none", o_slcpipeline, o_ptcalc);
      end else begin
        chk("pair_pl", o_slcpipeline, exp_pl_q.pop_front());
        chk("pair_pt", o_ptcalc, exp_pt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int k, base;
    rst = 1'b1; i_pl_data = '0; i_pl_valid = 1'b0; i_pt_data = '0; i_pt_valid = 1'b0; i_ready = 1'b1;
    tick(3);
    chk("rst_valid",  32'(o_valid), 0);
    chk("rst_slc",    o_slcpipeline, 0);
    chk("rst_pt",     o_ptcalc, 0);
    chk("rst_plovf",  32'(o_pl_overflow), 0);
    chk("rst_ptovf",  32'(o_pt_overflow), 0);
    chk("rst_tmo",    32'(o_timeout_cnt), 0);
    chk("rst_orph",   32'(o_orphan_cnt), 0);
    rst = 1'b0;
    tick(2);

    // Basic match: pT queued two cycles ahead of the pipeline word.
    push_pt(pt_w(12'h001, 20'h00123));
    tick(1);
    p = pl_w(7'h01, 1'b0, 20'h00123);
    expect_pair(p, pt_w(12'h001, 20'h00123));
    push_pl(p);
    chk("t1_lat_minus1", 32'(o_valid), 0);
    tick(1);
    chk("t1_lat", 32'(o_valid), 1);
    chk("t1_tmo", 32'(o_timeout_cnt), 0);
    chk("t1_orph", 32'(o_orphan_cnt), 0);
    tick(2);

    // Busy word bypasses the queued pT, which then pairs with a later word.
    push_pt(pt_w(12'h002, 20'h00077));
    tick(1);
    p = pl_w(7'h02, 1'b1, 20'h00099);
    expect_pair(p, 32'h0);
    push_pl(p);
    chk("t2_busy_minus1", 32'(o_valid), 0);
    tick(1);
    chk("t2_busy_valid", 32'(o_valid), 1);
    chk("t2_busy_pt", o_ptcalc, 0);
    tick(2);
    p = pl_w(7'h03, 1'b0, 20'h00077);
    expect_pair(p, pt_w(12'h002, 20'h00077));
    push_pl(p);
    tick(1);
    chk("t2_kept_pt_valid", 32'(o_valid), 1);
    tick(2);
    chk("t2_orph", 32'(o_orphan_cnt), 0);

    // Timeout: head waits exactly TIMEOUT cycles.
    p = pl_w(7'h04, 1'b0, 20'h00005);
    expect_pair(p, 32'h0);
    push_pl(p);
    tick(63);
    chk("t3_before_tmo", 32'(o_valid), 0);
    tick(1);
    chk("t3_tmo_valid", 32'(o_valid), 1);
    chk("t3_tmo_pt", o_ptcalc, 0);
    chk("t3_tmo_cnt", 32'(o_timeout_cnt), 1);
    tick(2);

    // Orphan: pT muid 3 discarded, 5 pairs.
    push_pt(pt_w(12'h005, 20'h00003));
    push_pt(pt_w(12'h006, 20'h00005));
    p = pl_w(7'h05, 1'b0, 20'h00005);
    expect_pair(p, pt_w(12'h006, 20'h00005));
    push_pl(p);
    tick(5);
    chk("t4_orph", 32'(o_orphan_cnt), 1);
    chk("t4_drained", 32'(exp_pl_q.size()), 0);
    chk("t4_tmo", 32'(o_timeout_cnt), 1);

    // Overflow: nine words into an eight-deep FIFO while held.
    i_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      p = pl_w(7'(8'h10 + i), 1'b0, 20'(32'h200 + i));
      if (i < 8) expect_pair(p, 32'h0);
      i_pl_data  = p;
      i_pl_valid = 1'b1;
      tick(1);
    end
    i_pl_valid = 1'b0;
    chk("t5_plovf", 32'(o_pl_overflow), 1);
    chk("t5_ptovf", 32'(o_pt_overflow), 0);
    k = 0;
    while (!o_valid && k < 100) begin tick(1); k++; end
    chk("t5_first_valid", 32'(o_valid), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_slc", o_slcpipeline, exp_pl_q[0]);
      chk("t5_hold_valid", 32'(o_valid), 1);
      tick(1);
    end
    base = n_emit;
    i_ready = 1'b1;
    k = 0;
    while (exp_pl_q.size() != 0 && k < 1000) begin tick(1); k++; end
    chk("t5_emitted", 32'(n_emit - base), 8);
    tick(80);
    chk("t5_no_ninth", 32'(n_emit - base), 8);
    chk("t5_tmo", 32'(o_timeout_cnt), 9);

    // Reset mid-operation with pending data in both FIFOs.
    i_ready = 1'b0;
    push_pl(pl_w(7'h09, 1'b1, 20'h00500));
    for (int i = 0; i < 4; i++) begin
      i_pl_data  = pl_w(7'(8'h20 + i), 1'b0, 20'(32'h600 + i));
      i_pt_data  = pt_w(12'(16'h20 + i), 20'(32'h700 + i));
      i_pl_valid = 1'b1;
      i_pt_valid = 1'b1;
      tick(1);
    end
    i_pl_valid = 1'b0;
    i_pt_valid = 1'b0;
    chk("t6_held_valid", 32'(o_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(o_valid), 0);
    chk("t6_rst_slc", o_slcpipeline, 0);
    chk("t6_rst_plovf", 32'(o_pl_overflow), 0);
    chk("t6_rst_tmo", 32'(o_timeout_cnt), 0);
    tick(2);
    rst = 1'b0;
    i_ready = 1'b1;
    base = n_emit;
    tick(100);
    chk("t6_no_stale", 32'(n_emit - base), 0);
    chk("t6_orph", 32'(o_orphan_cnt), 0);
    chk("t6_tmo_after", 32'(o_timeout_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
